mips32_prog_loader: RTL

Program loader that sits directly upstream of the two-phase pipelined MIPS32 core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the core's instruction/data memory from address 0, while holding the core halted. It then issues a one-cycle PC/branch-state initialise pulse, releases the core, and reports completion when the core executes HLT. It replaces the bench-side direct preloading of `Mem[]`, `PC`, `HALTED` and `TAKEN_BRANCH` with a synthesizable path.

---
 rtl/mips32_prog_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mips32_prog_loader.sv
// Program loader for the two-phase pipelined MIPS32 core.
// Streams instruction words into the core memory from address 0 while the
// core is held, pulses the PC/branch-state initialise, releases the core and
// reports completion once the core retires HLT.
module mips32_prog_loader #(
  parameter int         AW     = 10,
  parameter logic [5:0] HLT_OP = 6'h3f
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          cpu_pc_load,
  input  logic          cpu_halted,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic          w_accept;
  logic          w_term;
  logic          w_at_top;
  logic          w_clear;

  // A beat in the reset cycle must never reach memory.
  assign w_accept   = s_valid & s_ready & ~reset;
  assign w_term     = s_last | (s_data[31:26] == HLT_OP);
  assign w_at_top   = &r_addr;

  assign mem_we     = w_accept;
  assign mem_addr   = r_addr;
  assign mem_wdata  = s_data;
  assign word_count = r_count;

  // State register.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state outputs; hold is forced during reset so the core
  // stops in the same cycle reset is seen.
  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    cpu_hold     = 1'b1;
    cpu_pc_load  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    overflow     = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          // Termination takes priority: a last word in the top slot launches.
          if (w_term) begin
            w_state_next = S_LAUNCH;
          end else if (w_at_top) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_LAUNCH: begin
        cpu_pc_load  = 1'b1;
        busy         = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        busy     = 1'b1;
        if (cpu_halted) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_ERR: begin
        overflow = 1'b1;
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (reset) begin
      cpu_hold = 1'b1;
    end
  end

  // Write address and session word count; the address wraps on overflow while
  // the count keeps its extra bit to report a full memory.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_addr  <= r_addr + AW'(1);
      r_count <= r_count + (AW+1)'(1);
    end
  end

endmodule
